// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - four-channel 4-bit LED PWM driver with glitch-free level updates
//
// Purpose: drives four LEDs with 255-step PWM; each channel's 4-bit level L maps
// to duty L*17. New level sets are taken through a valid/ready handshake into
// a pending register and applied only at a PWM period boundary.
//
// Ports:
//   clk          - system clock
//   rst          - synchronous active-high reset
//   en           - PWM enable; when low, counters are held and LEDs are off
//   level_in     - four 4-bit levels, channel i in bits [4i+3:4i]
//   level_valid  - level_in is offered
//   level_ready  - a level set can be accepted this cycle
//   led          - registered PWM drive (polarity set by ACTIVE_LOW)
//   period_start - one-cycle pulse while cnt==0 is first presented after a period end

module led_pwm_driver #(
  parameter int unsigned CLK_DIV    = 196,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] level_in,
  input  logic        level_valid,
  output logic        level_ready,
  output logic [3:0]  led,
  output logic        period_start
);

  localparam logic [15:0] PSC_MAX = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LED_OFF = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [7:0]  CNT_MAX = 8'd254;

  logic [15:0] psc_q, psc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] active_q, active_d;
  logic [15:0] pending_q, pending_d;
  logic        pending_full_q, pending_full_d;
  logic [3:0]  led_q, led_d;
  logic        period_start_q, period_start_d;

  logic        tick;
  logic        period_end;
  logic        accept;
  logic [3:0]  on_raw;

  assign level_ready  = !pending_full_q && !rst;
  assign accept       = level_valid && level_ready;
  assign tick         = en && (psc_q == PSC_MAX);
  assign period_end   = tick && (cnt_q == CNT_MAX);
  assign led          = led_q;
  assign period_start = period_start_q;

  // Duty is {L,L} = L*17; cnt tops out at 254 so L=15 (duty 255) is always on.
  always_comb begin
    on_raw = '0;
    for (int i = 0; i < 4; i++) begin
      on_raw[i] = cnt_q < {active_q[4*i +: 4], active_q[4*i +: 4]};
    end
  end

  // Prescaler and PWM counter; both parked at zero while disabled so that a
  // rising en always begins a clean period.
  always_comb begin
    psc_d = psc_q;
    cnt_d = cnt_q;
    if (!en) begin
      psc_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      psc_d = '0;
      cnt_d = (cnt_q == CNT_MAX) ? 8'd0 : cnt_q + 8'd1;
    end else begin
      psc_d = psc_q + 16'd1;
    end
  end

  // Level storage. A full pending set moves to active at the period boundary,
  // or immediately when disabled since there is no period to protect. A set
  // accepted exactly on the boundary bypasses pending.
  always_comb begin
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    if (pending_full_q && (period_end || !en)) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end else if (accept) begin
      if (period_end) begin
        active_d = level_in;
      end else begin
        pending_d      = level_in;
        pending_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    led_d          = en ? (on_raw ^ LED_OFF) : LED_OFF;
    period_start_d = period_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q          <= '0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      led_q          <= LED_OFF;
      period_start_q <= 1'b0;
    end else begin
      psc_q          <= psc_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - scoreboard bench for led_pwm_driver against a time-based reference model

module tb_led_pwm_driver;

  localparam int DIV = 2;
  localparam int PER = DIV * 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        level_valid = 1'b0;
  logic [15:0] level_in = 16'h0000;

  logic        ready_a, ready_b;
  logic [3:0]  led_a, led_b;
  logic        ps_a, ps_b;

  always #5 clk = ~clk;

  led_pwm_driver #(.CLK_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .level_in(level_in), .level_valid(level_valid),
    .level_ready(ready_a), .led(led_a), .period_start(ps_a)
  );

  led_pwm_driver #(.CLK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .level_in(level_in), .level_valid(level_valid),
    .level_ready(ready_b), .led(led_b), .period_start(ps_b)
  );

  typedef struct packed {
    logic [3:0] on;
    logic       ps;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: run_t is the number of enabled clocks since counting
  // began, so the counter position is plain division of elapsed time.
  int          run_t = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_pending = '0;
  bit          m_full = 1'b0;
  logic [3:0]  m_on = '0;
  bit          m_ps = 1'b0;

  task automatic model_edge();
    int cnt_now;
    bit pe;
    bit acc;
    cnt_now = (run_t / DIV) % 255;
    pe = en && (((run_t + 1) % PER) == 0);
    if (rst) begin
      run_t = 0; m_active = '0; m_full = 1'b0; m_on = '0; m_ps = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        m_on[i] = en && (cnt_now < int'(m_active[4*i +: 4]) * 17);
      m_ps = pe;
      acc = level_valid && !m_full;
      if (m_full && (pe || !en)) begin
        m_active = m_pending; m_full = 1'b0;
      end else if (acc && pe) begin
        m_active = level_in;
      end else if (acc) begin
        m_pending = level_in; m_full = 1'b1;
      end
      run_t = en ? run_t + 1 : 0;
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    e.on = m_on; e.ps = m_ps; e.full = m_full;
    exp_q.push_back(e);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic exp_rdy;
      e = exp_q.pop_front();
      exp_rdy = !e.full && !rst;
      n_tests += 4;
      if (led_a !== e.on) begin
        n_fail++; $display("FAIL led cyc=%0d got=%b exp=%b", cyc, led_a, e.on);
      end
      if (led_b !== ~e.on) begin
        n_fail++; $display("FAIL led_active_low cyc=%0d got=%b exp=%b", cyc, led_b, ~e.on);
      end
      if (ps_a !== e.ps || ps_b !== e.ps) begin
        n_fail++; $display("FAIL period_start cyc=%0d got=%b/%b exp=%b", cyc, ps_a, ps_b, e.ps);
      end
      if (ready_a !== exp_rdy || ready_b !== exp_rdy) begin
        n_fail++; $display("FAIL level_ready cyc=%0d got=%b/%b exp=%b", cyc, ready_a, ready_b, exp_rdy);
      end
    end
  end

  task automatic wait_boundary(input int limit);
    int k;
    k = 0;
    while (!(en && ((run_t + 1) % PER) == 0 && !m_full) && k < limit) begin
      step(); k++;
    end
    n_tests++;
    if (k >= limit) begin
      n_fail++; $display("FAIL boundary_wait got=%0d cycles exp<%0d", k, limit);
    end
  endtask

  initial begin
    // Reset with both polarities observed off.
    steps(3);
    // Accept 0F80 on the first cycle after reset; it applies from period 2.
    rst = 1'b0; en = 1'b1; level_valid = 1'b1; level_in = 16'h0F80;
    step();
    level_valid = 1'b0;
    steps(3 * PER);

    // Hold valid across two values: A accepted, B refused until after the boundary.
    steps(100);
    level_valid = 1'b1; level_in = 16'h3C61;
    step();
    level_in = 16'hA5E2;
    steps(PER);
    level_valid = 1'b0;
    steps(PER);

    // Offer all-15 exactly on the period-end cycle with pending empty.
    wait_boundary(2 * PER);
    level_valid = 1'b1; level_in = 16'hFFFF;
    step();
    level_valid = 1'b0;
    steps(2 * PER);

    // Reset mid-period with pending full: pending must never be applied.
    steps(137);
    level_valid = 1'b1; level_in = 16'h1234;
    step();
    level_valid = 1'b0;
    steps(20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(2 * PER);

    // Disable mid-period, load a set while disabled, re-enable.
    level_valid = 1'b1; level_in = 16'h7F39;
    step();
    level_valid = 1'b0;
    steps(200);
    en = 1'b0;
    steps(10);
    level_valid = 1'b1; level_in = 16'h08C4;
    step();
    level_valid = 1'b0;
    steps(10);
    en = 1'b1;
    steps(2 * PER + 5);

    // Randomised traffic.
    for (int k = 0; k < 9000; k++) begin
      level_valid = ($urandom_range(0, 39) == 0);
      level_in    = 16'($urandom);
      if ($urandom_range(0, 1999) == 0) en = ~en;
      rst = ($urandom_range(0, 3999) == 0);
      step();
    end
    rst = 1'b0; level_valid = 1'b0;
    steps(4);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
